// File: rtl/cordic_arbiter.sv
// Arbitrates NUM_CLIENTS algorithm blocks onto one shared CORDIC core using a
// req/gnt/rel handshake, with a reset flush window on every ownership change.
module cordic_arbiter #(
  parameter int NUM_CLIENTS  = 6,
  parameter int PAYLOAD_W    = 96,
  parameter int ARB_MODE     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 0,
  parameter int IDXW         = $clog2(NUM_CLIENTS)
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic [NUM_CLIENTS-1:0]           req,
  input  logic [NUM_CLIENTS-1:0]           rel,
  input  logic [NUM_CLIENTS*PAYLOAD_W-1:0] payload_in,
  input  logic [NUM_CLIENTS-1:0]           cli_nrst,
  output logic [NUM_CLIENTS-1:0]           gnt,
  output logic                             busy,
  output logic [IDXW-1:0]                  owner,
  output logic [PAYLOAD_W-1:0]             cordic_payload,
  output logic                             cordic_nreset,
  output logic                             timeout_err
);

  // Handshake: a client raises req (level) and keeps it high until it is done;
  // gnt[k] marks ownership; ownership ends when the owner pulses rel[k] or drops
  // req[k]. Inputs from non-owners are ignored while the core is owned.

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CLIENTS - 1);
  localparam logic [NUM_CLIENTS-1:0] ONE = NUM_CLIENTS'(1);

  typedef enum logic [1:0] {IDLE, FLUSH, OWN} state_t;

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [FCW-1:0]  flush_cnt;
  logic [TCW-1:0]  own_cnt;

  logic [PAYLOAD_W-1:0] slice [NUM_CLIENTS];

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_slice
    assign slice[k] = payload_in[k*PAYLOAD_W +: PAYLOAD_W];
  end

  // Round-robin: first request at or above the base pointer, else wrap to the
  // lowest request. Fixed priority is the same search with the base at zero.
  logic [IDXW-1:0] base;
  logic            hi_found;
  logic            lo_found;
  logic [IDXW-1:0] hi_idx;
  logic [IDXW-1:0] lo_idx;
  logic [IDXW-1:0] win_idx;

  assign base = (ARB_MODE == 1) ? rr_ptr : '0;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDXW'(i);
        if (IDXW'(i) >= base) begin
          hi_found = 1'b1;
          hi_idx   = IDXW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  logic            own_rel;
  logic            timeout_hit;
  logic [IDXW-1:0] next_ptr;

  assign own_rel     = rel[owner] || !req[owner];
  assign timeout_hit = (TIMEOUT > 0) && (own_cnt == TCW'(TIMEOUT));
  assign next_ptr    = (owner == LAST_IDX) ? '0 : owner + IDXW'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      gnt            <= '0;
      busy           <= 1'b0;
      owner          <= '0;
      cordic_payload <= '0;
      cordic_nreset  <= 1'b0;
      timeout_err    <= 1'b0;
      rr_ptr         <= '0;
      flush_cnt      <= '0;
      own_cnt        <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          gnt            <= '0;
          cordic_payload <= '0;
          cordic_nreset  <= 1'b0;
          if (en && lo_found) begin
            owner     <= win_idx;
            flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            busy      <= 1'b1;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          gnt            <= '0;
          cordic_payload <= '0;
          cordic_nreset  <= 1'b0;
          if (!req[owner]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (flush_cnt == '0) begin
            // The owner's bundle is presented on the same edge as its grant.
            gnt            <= ONE << owner;
            cordic_payload <= slice[owner];
            cordic_nreset  <= cli_nrst[owner];
            own_cnt        <= TCW'(1);
            state          <= OWN;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        OWN: begin
          if (own_rel || timeout_hit) begin
            gnt            <= '0;
            busy           <= 1'b0;
            cordic_payload <= '0;
            cordic_nreset  <= 1'b0;
            rr_ptr         <= next_ptr;
            timeout_err    <= !own_rel;
            state          <= IDLE;
          end else begin
            cordic_payload <= slice[owner];
            cordic_nreset  <= cli_nrst[owner];
            own_cnt        <= own_cnt + TCW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: a round-robin/timeout instance and a
// fixed-priority instance, grants checked by a scoreboard monitor.
module tb_cordic_arbiter;
  localparam int N  = 6;
  localparam int PW = 96;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic nrst;
  logic en;
  logic [N-1:0]    req_rr, rel_rr, req_fp, rel_fp, cli_nrst;
  logic [N*PW-1:0] payload_in;

  logic [N-1:0]  gnt_rr, gnt_fp;
  logic          busy_rr, busy_fp, cnr_rr, cnr_fp, terr_rr, terr_fp;
  logic [IW-1:0] owner_rr, owner_fp;
  logic [PW-1:0] cpay_rr, cpay_fp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_rr_q[$];
  logic [N-1:0] exp_fp_q[$];

  cordic_arbiter #(.NUM_CLIENTS(N), .PAYLOAD_W(PW), .ARB_MODE(1), .FLUSH_CYCLES(2), .TIMEOUT(8))
    dut_rr (.clk(clk), .nrst(nrst), .en(en), .req(req_rr), .rel(rel_rr), .payload_in(payload_in),
            .cli_nrst(cli_nrst), .gnt(gnt_rr), .busy(busy_rr), .owner(owner_rr),
            .cordic_payload(cpay_rr), .cordic_nreset(cnr_rr), .timeout_err(terr_rr));

  cordic_arbiter #(.NUM_CLIENTS(N), .PAYLOAD_W(PW), .ARB_MODE(0), .FLUSH_CYCLES(2), .TIMEOUT(0))
    dut_fp (.clk(clk), .nrst(nrst), .en(en), .req(req_fp), .rel(rel_fp), .payload_in(payload_in),
            .cli_nrst(cli_nrst), .gnt(gnt_fp), .busy(busy_fp), .owner(owner_fp),
            .cordic_payload(cpay_fp), .cordic_nreset(cnr_fp), .timeout_err(terr_fp));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst   = 1'b0;
    req_rr = '0;
    rel_rr = '0;
    req_fp = '0;
    rel_fp = '0;
    repeat (2) tick();
    nrst = 1'b1;
    tick();
  endtask

  // scoreboard monitor: every new grant pops the expected one-hot grant
  logic [N-1:0] prev_rr = '0;
  logic [N-1:0] prev_fp = '0;
  always @(negedge clk) begin
    if (gnt_rr != '0 && prev_rr == '0) begin
      if (exp_rr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rr_grant: got %b expected no grant", gnt_rr);
      end else begin
        check("rr_grant", PW'(gnt_rr), PW'(exp_rr_q.pop_front()));
      end
    end
    if (gnt_fp != '0 && prev_fp == '0) begin
      if (exp_fp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fp_grant: got %b expected no grant", gnt_fp);
      end else begin
        check("fp_grant", PW'(gnt_fp), PW'(exp_fp_q.pop_front()));
      end
    end
    prev_rr = gnt_rr;
    prev_fp = gnt_fp;
  end

  // driver tasks
  task automatic wait_grant(input int which, output int gap, output int idx);
    logic [N-1:0] g;
    gap = 0;
    idx = -1;
    for (int c = 0; c < 20; c++) begin
      g = (which != 0) ? gnt_fp : gnt_rr;
      if (g != '0) break;
      tick();
      gap++;
    end
    g = (which != 0) ? gnt_fp : gnt_rr;
    for (int k = 0; k < N; k++) if (g[k]) idx = k;
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_wait: got no grant after %0d cycles expected a grant", gap);
    end
  endtask

  task automatic serve(input int which, input int n);
    int gap;
    int idx;
    for (int g = 0; g < n; g++) begin
      wait_grant(which, gap, idx);
      if (idx < 0) return;
      check("handover_gap", PW'(gap), PW'(3));
      repeat (3) tick();
      if (which != 0) rel_fp[idx] = 1'b1; else rel_rr[idx] = 1'b1;
      tick();
      rel_fp = '0;
      rel_rr = '0;
      if (g == n - 1) begin
        req_fp = '0;
        req_rr = '0;
      end
    end
  endtask

  initial begin
    int gap;
    int idx;
    logic [PW-1:0] v;
    nrst = 1'b0;
    en = 1'b1;
    req_rr = '0; rel_rr = '0; req_fp = '0; rel_fp = '0;
    cli_nrst = '1;
    for (int k = 0; k < N; k++)
      payload_in[k*PW +: PW] = {32'hC0DE_0000 + 32'(k), 64'h0123_4567_89AB_CDEF};

    // reset state
    repeat (2) tick();
    check("rst_gnt", PW'(gnt_rr), '0);
    check("rst_busy", PW'(busy_rr), '0);
    check("rst_owner", PW'(owner_rr), '0);
    check("rst_payload", cpay_rr, '0);
    check("rst_cnreset", PW'(cnr_rr), '0);
    check("rst_terr", PW'(terr_rr), '0);
    check("rst_fp_outs", PW'({gnt_fp, busy_fp, owner_fp, cnr_fp, terr_fp}), '0);
    check("rst_fp_payload", cpay_fp, '0);
    nrst = 1'b1;
    tick();

    // single client 3: flush window, grant, payload/nreset tracking, release
    exp_rr_q.push_back(6'b001000);
    req_rr = 6'b001000;
    tick();
    check("flush1_busy", PW'(busy_rr), PW'(1));
    check("flush1_gnt", PW'(gnt_rr), '0);
    check("flush1_cnreset", PW'(cnr_rr), '0);
    tick();
    check("flush2_gnt", PW'(gnt_rr), '0);
    check("flush2_cnreset", PW'(cnr_rr), '0);
    tick();
    check("own_gnt", PW'(gnt_rr), PW'(6'b001000));
    check("own_owner", PW'(owner_rr), PW'(3));
    v = 96'hAAAA_5555_1234_5678_9ABC_DEF0;
    payload_in[3*PW +: PW] = v;
    tick();
    check("payload_v1", cpay_rr, v);
    check("own_cnreset", PW'(cnr_rr), PW'(1));
    v = 96'h0F0F_F0F0_0000_FFFF_8765_4321;
    payload_in[3*PW +: PW] = v;
    payload_in[2*PW +: PW] = ~v;
    tick();
    check("payload_v2", cpay_rr, v);
    cli_nrst[3] = 1'b0;
    tick();
    check("cli_nrst_low", PW'(cnr_rr), '0);
    cli_nrst[3] = 1'b1;
    cli_nrst[5] = 1'b0;
    tick();
    check("cli_nrst_high", PW'(cnr_rr), PW'(1));
    cli_nrst[5] = 1'b1;
    rel_rr[5] = 1'b1;
    tick();
    rel_rr = '0;
    check("nonowner_rel", PW'(gnt_rr), PW'(6'b001000));
    rel_rr[3] = 1'b1;
    tick();
    rel_rr = '0;
    req_rr = '0;
    check("rel_gnt", PW'(gnt_rr), '0);
    check("rel_cnreset", PW'(cnr_rr), '0);
    check("rel_busy", PW'(busy_rr), '0);
    check("rel_payload", cpay_rr, '0);

    // en=0 blocks new grants
    en = 1'b0;
    req_rr = 6'b000010;
    repeat (4) tick();
    check("en0_gnt", PW'(gnt_rr), '0);
    check("en0_busy", PW'(busy_rr), '0);
    en = 1'b1;
    do_reset();

    // round-robin order and fixed priority under the same request pattern
    exp_rr_q.push_back(6'b000001);
    exp_rr_q.push_back(6'b000100);
    exp_rr_q.push_back(6'b100000);
    exp_rr_q.push_back(6'b000001);
    req_rr = 6'b100101;
    serve(0, 4);
    for (int i = 0; i < 3; i++) exp_fp_q.push_back(6'b000001);
    req_fp = 6'b100101;
    serve(1, 3);

    // timeout on client 1, then client 2 wins; release coinciding with timeout
    exp_rr_q.push_back(6'b000010);
    exp_rr_q.push_back(6'b000100);
    req_rr = 6'b000110;
    wait_grant(0, gap, idx);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_hold_gnt", PW'(gnt_rr), PW'(6'b000010));
      check("to_hold_terr", PW'(terr_rr), '0);
    end
    tick();
    check("to_exit_gnt", PW'(gnt_rr), '0);
    check("to_exit_terr", PW'(terr_rr), PW'(1));
    check("to_exit_busy", PW'(busy_rr), '0);
    tick();
    check("to_pulse_end", PW'(terr_rr), '0);
    wait_grant(0, gap, idx);
    repeat (7) tick();
    rel_rr[2] = 1'b1;
    tick();
    rel_rr = '0;
    req_rr = '0;
    check("coincide_terr", PW'(terr_rr), '0);
    check("coincide_gnt", PW'(gnt_rr), '0);

    // en=0 during OWN keeps the grant until release
    exp_rr_q.push_back(6'b000010);
    req_rr = 6'b000010;
    wait_grant(0, gap, idx);
    en = 1'b0;
    repeat (3) tick();
    check("en0_own_gnt", PW'(gnt_rr), PW'(6'b000010));
    rel_rr[1] = 1'b1;
    tick();
    rel_rr = '0;
    check("en0_rel_gnt", PW'(gnt_rr), '0);
    repeat (3) tick();
    check("en0_idle_busy", PW'(busy_rr), '0);
    req_rr = '0;
    en = 1'b1;

    // abort in FLUSH: no grant, pointer (2) unchanged so client 3 beats client 1
    req_rr = 6'b010000;
    tick();
    check("abort_busy", PW'(busy_rr), PW'(1));
    tick();
    req_rr = '0;
    tick();
    check("abort_idle_busy", PW'(busy_rr), '0);
    repeat (2) tick();
    check("abort_gnt", PW'(gnt_rr), '0);
    exp_rr_q.push_back(6'b001000);
    req_rr = 6'b001010;
    wait_grant(0, gap, idx);
    repeat (2) tick();

    // asynchronous reset during OWN
    nrst = 1'b0;
    #1;
    check("async_gnt", PW'(gnt_rr), '0);
    check("async_busy", PW'(busy_rr), '0);
    check("async_owner", PW'(owner_rr), '0);
    check("async_payload", cpay_rr, '0);
    check("async_cnreset", PW'(cnr_rr), '0);
    req_rr = '0;
    tick();
    nrst = 1'b1;
    repeat (3) tick();

    check("rr_queue_empty", PW'(exp_rr_q.size()), '0);
    check("fp_queue_empty", PW'(exp_fp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
